// File: rtl/sync_pkg.sv
// Shared constants and helpers for clock-domain-crossing blocks.
package sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    // Ceiling log2; callers size counters with clog2(max_value + 1).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_filter_bank_if.sv
// Bundle of the filter bank's mode control, raw inputs and conditioned outputs.
interface sync_filter_bank_if #(
    parameter int NCH = 8
);
    logic           filt_en;
    logic [NCH-1:0] in_async;
    logic [NCH-1:0] level_out;
    logic [NCH-1:0] rise_pulse;
    logic [NCH-1:0] fall_pulse;
    logic           change_any;

    modport master (
        output filt_en,
        output in_async,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  change_any
    );

    modport slave (
        input  filt_en,
        input  in_async,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output change_any
    );
endinterface

// File: rtl/sync_filter_ch.sv
// One conditioner channel: synchroniser chain, stable-count glitch filter and
// registered edge pulses coincident with the filtered level change.
module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic INIT_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic filt_en,
    input  logic mode_chg,
    input  logic in_async,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
    localparam int CNT_W  = clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_reg;

    logic             sync_q;
    logic             level_reg;
    logic             level_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             rise_reg;
    logic             rise_next;
    logic             fall_reg;
    logic             fall_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= {STAGES{INIT_VAL}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], in_async};
        end
    end

    assign sync_q = sync_reg[STAGES-1];

    // A mode change only clears the count; the level is held so the switch itself never pulses.
    always_comb begin
        level_next = level_reg;
        cnt_next   = cnt_reg;
        if (mode_chg) begin
            cnt_next = '0;
        end else if (!filt_en) begin
            level_next = sync_q;
            cnt_next   = '0;
        end else if (sync_q == level_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            level_next = sync_q;
            cnt_next   = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
        rise_next = ~level_reg &  level_next;
        fall_next =  level_reg & ~level_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_reg <= INIT_VAL;
            cnt_reg   <= '0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    assign level_out  = level_reg;
    assign rise_pulse = rise_reg;
    assign fall_pulse = fall_reg;

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel asynchronous-input conditioner: NCH independent sync/filter/edge
// channels sharing a filter-enable control; change_any is the only cross-channel logic.
module sync_filter_bank
    import sync_pkg::*;
#(
    parameter int             NCH         = 8,
    parameter int             SYNC_STAGES = 2,
    parameter int             FILT_CYCLES = 4,
    parameter logic [NCH-1:0] INIT_VAL    = '0
) (
    input  logic              clk,
    input  logic              rst,
    sync_filter_bank_if.slave bus
);

    logic           filt_en_reg;
    logic           mode_chg;
    logic [NCH-1:0] level_vec;
    logic [NCH-1:0] rise_vec;
    logic [NCH-1:0] fall_vec;

    // Previous mode, so every channel can clear its count on the cycle filt_en changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_en_reg <= 1'b1;
        end else begin
            filt_en_reg <= bus.filt_en;
        end
    end

    assign mode_chg = bus.filt_en ^ filt_en_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            sync_filter_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_CYCLES (FILT_CYCLES),
                .INIT_VAL    (INIT_VAL[gi])
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .filt_en    (bus.filt_en),
                .mode_chg   (mode_chg),
                .in_async   (bus.in_async[gi]),
                .level_out  (level_vec[gi]),
                .rise_pulse (rise_vec[gi]),
                .fall_pulse (fall_vec[gi])
            );
        end
    endgenerate

    assign bus.level_out  = level_vec;
    assign bus.rise_pulse = rise_vec;
    assign bus.fall_pulse = fall_vec;
    assign bus.change_any = |(rise_vec | fall_vec);

endmodule
